obg_frame_gen: RTL
==================

# obg_frame_gen

Parametrised original-bits generator for the OFDM transmit chain. It merges SIGNAL-field and DATA-field bit generation into one framed stream and emits DW bits per beat. Each DATA field carries SERVICE, PSDU, tail and symbol-aligned pad bits, with ready/valid backpressure toward the encoder. It sits at the head of the PHY TX datapath, ahead of the scrambler and convolutional encoder.

## Interface
- DW, 1, output bits per beat; legal values 1, 2, 4.
- PRBS_SEED, 9'h1FF, PRBS9 seed loaded at every frame start; must be nonzero.
- clk  input  1  working clock.
- rst  input  1  reset; synchronous, active high.
- di_len  input  12  PSDU length in bytes; legal range 1..4095.
- di_rate  input  4  RATE code; di_rate[3] = R1, transmitted first.
- di_vld  input  1  frame request valid.
- di_rdy  output  1  request accepted when di_vld & di_rdy.
- di_err  output  1  one-cycle pulse when a request is rejected.
- do  output  DW  bit chunk; do[0] is earliest in transmission order.
- do_vld  output  1  chunk valid.
- do_rdy  input  1  downstream ready; a beat transfers on do_vld & do_rdy.
- do_sof  output  1  first SIGNAL beat of a frame.
- do_eof  output  1  last DATA beat of a frame.
- do_sig  output  1  beat belongs to the SIGNAL field.
- do_sym_last  output  1  last beat of an OFDM symbol (SIGNAL or DATA).
- sig_word  output  24  SIGNAL bits of the current frame, bit 0 first; held until the next accept.

## Operation
- FSM states: IDLE, SIG, SVC, PSDU, ZERO.
- di_rdy = 1 only in IDLE.
- Accept sequence: latch len and rate, decode NDBPS, build sig_word, reseed the PRBS, then go to SIG.
- NDBPS decode: 1101→24, 1111→36, 0101→48, 0111→72, 1001→96, 1011→144, 0001→192, 0011→216.
- Rejection:
  - Causes: any other rate code, or di_len = 0.
  - The request is still consumed (di_rdy high).
  - di_err pulses the next cycle; FSM stays in IDLE; no beats are emitted.
- sig_word layout: [3:0] = R1..R4; [4] = 0; [16:5] = LENGTH LSB first; [17] = even parity over [16:0]; [23:18] = 0.
- SIG: 24/DW beats; do_sym_last on the final beat.
- SVC: 16 zero bits.
- PSDU: 8·len bits, LSB of each byte first; the source is set by the macro in Configuration.
- ZERO: zero bits while fewer than 6 tail bits have been sent, or while the symbol bit counter ≠ 0. Result: N_DATA = NDBPS·ceil((22+8·len)/NDBPS).
- Symbol bit counter:
  - Cleared at SVC entry; advances DW per accepted DATA beat; wraps at NDBPS.
  - do_sym_last asserts on the beat where it wraps.
- do_eof is on the last ZERO beat, coincident with do_sym_last. FSM then returns to IDLE.
- Arithmetic widths: PSDU bit counter is 15 bits (max 32760); symbol counter is 8 bits.
- Phase boundaries fall on multiples of DW, so one chunk never spans two states.

## Timing
- Reset values: di_rdy = 1 (after the reset cycle), do_vld = 0, do = 0, all flags = 0, di_err = 0, sig_word = 0. PRBS state = PRBS_SEED; FSM = IDLE.
- Latency: request accepted at cycle T → first SIGNAL beat valid at T+1.
- No bubbles between fields while do_rdy = 1.
- Backpressure: with do_vld & !do_rdy, do and all flags hold stable and no state, counter or PRBS advances.
- Turnaround: eof accepted at cycle E → di_rdy = 1 at E+1. Minimum inter-frame gap is 1 cycle.
- rst during a frame: next cycle do_vld = 0, FSM = IDLE, PRBS reseeded. The partial frame is abandoned; no eof is emitted.
- di_vld outside IDLE is ignored (di_rdy = 0).

## Configuration
- OBG_PRBS_PLD_EN:
  - Defined: PSDU bits come from PRBS9 x^9+x^5+1. Per bit: n = s[8]^s[4]; output n; s = {s[7:0], n}. Reseeded each frame.
  - Undefined: PSDU byte k = k mod 256, counted from 0 each frame, LSB first.

## Test plan
- DW=1, macro off, rate 1101, len 100 → sig_word bits 0..23 = 1101 0 001001100000 0 000000. Then 840 DATA beats: 16 zeros, bytes 0..99, then 24 zeros. do_sym_last every 24 beats; 36 symbols total including SIGNAL; do_eof on beat 864.
- DW=4, macro on, rate 0011, len 1 → 6 SIG beats, then 54 DATA beats. PSDU bits 16..23 = 0,0,0,0,0,1,1,1. ZERO covers bits 24..215. eof coincides with the only DATA do_sym_last.
- Rate 0000, len 5 → consumed, di_err pulse, no do_vld. Then rate 1101, len 0 → same result.
- DW=2, rate 1011, len 50: hold do_rdy = 0 for 5 cycles mid-PSDU → do and flags stable. Full bitstream matches the no-stall run; the symbol count N_SYM = 3 is unchanged.
- Back-to-back: di_vld held high across two frames → second accept exactly 1 cycle after the first frame's eof. The second PRBS sequence restarts from the seed.
- Assert rst in the PSDU phase → do_vld = 0 next cycle, di_rdy = 1. A new frame then produces an exact fresh sequence.

Source files
------------

// File: rtl/obg_frame_gen.sv
// Framed SIGNAL/DATA original-bits generator for the OFDM TX head, DW bits per beat.
// Build option OBG_PRBS_PLD_EN: PSDU bits from PRBS9 when defined, byte-count ramp otherwise.
module obg_frame_gen #(
    parameter int unsigned DW        = 1,
    parameter logic [8:0]  PRBS_SEED = 9'h1FF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [11:0]   di_len,
    input  logic [3:0]    di_rate,
    input  logic          di_vld,
    output logic          di_rdy,
    output logic          di_err,
    output logic [DW-1:0] do_data,
    output logic          do_vld,
    input  logic          do_rdy,
    output logic          do_sof,
    output logic          do_eof,
    output logic          do_sig,
    output logic          do_sym_last,
    output logic [23:0]   sig_word
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SIG  = 3'd1;
    localparam logic [2:0] ST_SVC  = 3'd2;
    localparam logic [2:0] ST_PSDU = 3'd3;
    localparam logic [2:0] ST_ZERO = 3'd4;

    localparam logic [14:0] DW15 = 15'(DW);
    localparam logic [8:0]  DW9  = 9'(DW);

    logic [2:0]  r_state;
    logic [11:0] r_len;
    logic [7:0]  r_ndbps;
    logic [23:0] r_sig_word;
    logic [14:0] r_cnt;
    logic [7:0]  r_sym;
    logic [8:0]  r_prbs;
    logic        r_err;

    logic [2:0]    w_state_d;
    logic [11:0]   w_len_d;
    logic [7:0]    w_ndbps_d;
    logic [23:0]   w_sig_d;
    logic [14:0]   w_cnt_d;
    logic [7:0]    w_sym_d;
    logic [8:0]    w_prbs_d;
    logic          w_err_d;

    logic          w_fire;
    logic          w_is_data;
    logic [7:0]    w_req_ndbps;
    logic          w_req_ok;
    logic          w_par;
    logic [23:0]   w_sig_new;
    logic [14:0]   w_cnt_nxt;
    logic [8:0]    w_sym_sum;
    logic          w_sym_wrap;
    logic          w_sig_last;
    logic          w_svc_last;
    logic          w_psdu_last;
    logic          w_zero_last;
    logic [7:0]    w_byte;
    logic [DW-1:0] w_sig_chunk;
    logic [DW-1:0] w_ramp_chunk;
    logic [DW-1:0] w_prbs_chunk;
    logic [8:0]    w_prbs_s;
    logic          w_prbs_n;
    logic [DW-1:0] w_pld_chunk;

    // Zero means "unsupported rate code".
    function automatic logic [7:0] f_ndbps(input logic [3:0] rate);
        case (rate)
            4'b1101: f_ndbps = 8'd24;
            4'b1111: f_ndbps = 8'd36;
            4'b0101: f_ndbps = 8'd48;
            4'b0111: f_ndbps = 8'd72;
            4'b1001: f_ndbps = 8'd96;
            4'b1011: f_ndbps = 8'd144;
            4'b0001: f_ndbps = 8'd192;
            4'b0011: f_ndbps = 8'd216;
            default: f_ndbps = 8'd0;
        endcase
    endfunction

    assign w_fire      = (r_state != ST_IDLE) && do_rdy;
    assign w_is_data   = (r_state == ST_SVC) || (r_state == ST_PSDU) || (r_state == ST_ZERO);
    assign w_req_ndbps = f_ndbps(di_rate);
    assign w_req_ok    = (w_req_ndbps != 8'd0) && (di_len != 12'd0);
    assign w_par       = ^{di_len, di_rate};
    assign w_sig_new   = {6'd0, w_par, di_len, 1'b0, di_rate[0], di_rate[1], di_rate[2], di_rate[3]};

    assign w_cnt_nxt   = r_cnt + DW15;
    assign w_sym_sum   = {1'b0, r_sym} + DW9;
    assign w_sym_wrap  = (w_sym_sum == {1'b0, r_ndbps});
    assign w_sig_last  = (r_state == ST_SIG) && (r_cnt == 15'd24 - DW15);
    assign w_svc_last  = (r_cnt == 15'd16 - DW15);
    assign w_psdu_last = (r_cnt == {r_len, 3'b000} - DW15);
    // Tail done and symbol filled: both must hold on the closing beat.
    assign w_zero_last = (r_state == ST_ZERO) && w_sym_wrap && (w_cnt_nxt >= 15'd6);

    assign w_byte       = r_cnt[10:3];
    assign w_sig_chunk  = DW'(r_sig_word >> r_cnt[4:0]);
    assign w_ramp_chunk = DW'(w_byte >> r_cnt[2:0]);

    // Each new PRBS bit enters at the top, so the earliest bit ends up at bit 0.
    always_comb begin
        w_prbs_s     = r_prbs;
        w_prbs_n     = 1'b0;
        w_prbs_chunk = '0;
        for (int unsigned i = 0; i < DW; i++) begin
            w_prbs_n     = w_prbs_s[8] ^ w_prbs_s[4];
            w_prbs_s     = {w_prbs_s[7:0], w_prbs_n};
            w_prbs_chunk = (w_prbs_chunk >> 1) | (DW'(w_prbs_n) << (DW - 1));
        end
    end

`ifdef OBG_PRBS_PLD_EN
    assign w_pld_chunk = w_prbs_chunk;
`else
    assign w_pld_chunk = w_ramp_chunk;
`endif

    always_comb begin
        w_state_d = r_state;
        w_len_d   = r_len;
        w_ndbps_d = r_ndbps;
        w_sig_d   = r_sig_word;
        w_cnt_d   = r_cnt;
        w_sym_d   = r_sym;
        w_prbs_d  = r_prbs;
        w_err_d   = 1'b0;
        if (w_fire && w_is_data) begin
            w_sym_d = w_sym_wrap ? 8'd0 : w_sym_sum[7:0];
        end
        case (r_state)
            ST_IDLE: begin
                if (di_vld) begin
                    if (w_req_ok) begin
                        w_len_d   = di_len;
                        w_ndbps_d = w_req_ndbps;
                        w_sig_d   = w_sig_new;
                        w_prbs_d  = PRBS_SEED;
                        w_cnt_d   = 15'd0;
                        w_state_d = ST_SIG;
                    end else begin
                        w_err_d = 1'b1;
                    end
                end
            end
            ST_SIG: begin
                if (w_fire) begin
                    if (w_sig_last) begin
                        w_state_d = ST_SVC;
                        w_cnt_d   = 15'd0;
                        w_sym_d   = 8'd0;
                    end else begin
                        w_cnt_d = w_cnt_nxt;
                    end
                end
            end
            ST_SVC: begin
                if (w_fire) begin
                    if (w_svc_last) begin
                        w_state_d = ST_PSDU;
                        w_cnt_d   = 15'd0;
                    end else begin
                        w_cnt_d = w_cnt_nxt;
                    end
                end
            end
            ST_PSDU: begin
                if (w_fire) begin
                    w_prbs_d = w_prbs_s;
                    if (w_psdu_last) begin
                        w_state_d = ST_ZERO;
                        w_cnt_d   = 15'd0;
                    end else begin
                        w_cnt_d = w_cnt_nxt;
                    end
                end
            end
            ST_ZERO: begin
                if (w_fire) begin
                    if (w_zero_last) begin
                        w_state_d = ST_IDLE;
                        w_cnt_d   = 15'd0;
                    end else begin
                        w_cnt_d = w_cnt_nxt;
                    end
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_len      <= 12'd0;
            r_ndbps    <= 8'd0;
            r_sig_word <= 24'd0;
            r_cnt      <= 15'd0;
            r_sym      <= 8'd0;
            r_prbs     <= PRBS_SEED;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_len      <= w_len_d;
            r_ndbps    <= w_ndbps_d;
            r_sig_word <= w_sig_d;
            r_cnt      <= w_cnt_d;
            r_sym      <= w_sym_d;
            r_prbs     <= w_prbs_d;
            r_err      <= w_err_d;
        end
    end

    always_comb begin
        do_data = '0;
        case (r_state)
            ST_SIG:  do_data = w_sig_chunk;
            ST_PSDU: do_data = w_pld_chunk;
            default: do_data = '0;
        endcase
    end

    assign di_rdy      = (r_state == ST_IDLE);
    assign di_err      = r_err;
    assign do_vld      = (r_state != ST_IDLE);
    assign do_sof      = (r_state == ST_SIG) && (r_cnt == 15'd0);
    assign do_sig      = (r_state == ST_SIG);
    assign do_sym_last = w_sig_last || (w_is_data && w_sym_wrap);
    assign do_eof      = w_zero_last;
    assign sig_word    = r_sig_word;

endmodule
